edge_seq_tracker: RTL
=====================

# edge_seq_tracker

Synthesizable edge-sequence tracker that consumes the stimulus stage's outputs: a single-cycle event pulse `ev` and two level signals `sig1`/`sig2`. It steps through a fixed four-stage sequence of edge/event conditions and reports per-step hits, sequence completion, timeouts and a completed-sequence count. It turns the event-control wait chain into clocked hardware that the checker stage downstream can consume.

## Interface
- `TMO_W`, 8, width of the per-step timeout limit and wait counter
- `CNT_W`, 16, width of the completed-sequence counter

- `clk`  in  1  sole clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  FSM advance enable; edge registers track regardless
- `ev`  in  1  event pulse, one cycle wide
- `sig1`  in  1  level input, idle value 0
- `sig2`  in  1  level input, idle value 1
- `tmo_lim`  in  TMO_W  cycles allowed per step; 0 disables timeout
- `step`  out  2  current wait step, 0..3 (A..D)
- `hit`  out  1  one-cycle pulse: current step's condition satisfied
- `hit_step`  out  2  step index that hit, valid with `hit`
- `done`  out  1  one-cycle pulse: step D satisfied, sequence complete
- `timeout`  out  1  one-cycle pulse: step abandoned on timeout
- `seq_cnt`  out  CNT_W  completed sequences, wraps modulo 2^CNT_W
- `wait_cyc`  out  TMO_W  cycles spent in current step, saturating

## Operation
- Edge detect: `s1_q`, `s2_q` register previous inputs every cycle, including while `en`=0. rise1 = sig1 & ~s1_q; fall1 = ~sig1 & s1_q; rise2/fall2 likewise.
- States and wake conditions:
  - A: rise1 | ev.
  - B: rise2 | ev.
  - C: rise1 | fall2.
  - D: fall1 | rise2.
- On a hit in A/B/C: advance to next state, pulse `hit`, set `hit_step` to the old step, clear `wait_cyc`.
- On a hit in D: go to A, pulse `hit` and `done`, increment `seq_cnt`, clear `wait_cyc`.
- Only the current state's condition is evaluated. An edge that satisfies the next state in the same cycle is consumed and lost; one hit per cycle maximum.
- Timeout: when `tmo_lim`≠0, no hit, and `wait_cyc`==`tmo_lim`−1, go to A, pulse `timeout`, clear `wait_cyc`. Hit has priority over timeout in the same cycle.
- `en`=0: state, `wait_cyc` and `seq_cnt` hold; no pulses. Edges occurring while disabled are lost.
- `wait_cyc` increments each enabled non-hit cycle and saturates at all-ones.

## Timing
- Reset values:
  - `step`=0 (A); `hit`=`done`=`timeout`=0; `hit_step`=0; `seq_cnt`=0; `wait_cyc`=0.
  - `s1_q`=0, `s2_q`=1, so idle levels out of reset produce no edge.
- All outputs are registered. Inputs sampled at posedge N drive outputs visible after posedge N, i.e. one-clock latency from input change to `hit`.
- `rst` asserted mid-sequence: next posedge returns to A with all outputs at reset values and no `done`/`timeout` pulse; pending edges are discarded.
- `seq_cnt` wraps from 2^CNT_W−1 to 0 on `done`, with no flag.
- `tmo_lim` is sampled live each cycle. Lowering it below the current `wait_cyc` causes no timeout until `wait_cyc` wraps (it does not, since it saturates), so that step waits indefinitely. This is intended.

## Structure
- Package `edge_seq_pkg`: `typedef enum logic [1:0] {ST_A, ST_B, ST_C, ST_D} seq_state_t;` plus the localparam reset levels for sig1/sig2.
- One natural sub-module, `edge_det2`: the two-signal edge-register pair producing rise/fall for sig1 and sig2 with parameterised reset levels.
- Top: FSM, wait counter, sequence counter, output registers.

## Test plan
- Reset then idle 20 cycles (sig1=0, sig2=1, no ev) -> `step`=0, no pulses, `wait_cyc`=20 with `tmo_lim`=0.
- Five-phase stimulus repeated (ev, sig1↑, sig2↓, sig1↓, sig1↑, one per cycle) -> hits at A (ev), B (next ev), C (sig1↑), D (sig1↓); `done` once, `seq_cnt`=1.
- `tmo_lim`=4, enter B, hold inputs -> `timeout` pulse 4 cycles after entering B, `step`=0; same-cycle ev at the limit -> hit wins, no timeout.
- ev and sig1↑ same cycle in A -> single hit, `step`=1; the sig1↑ is not credited to B.
- `en`=0 during sig2↑ in B, then `en`=1 -> no hit; B still waiting, `wait_cyc` unchanged across the disabled window.
- `rst` pulse while in D with `seq_cnt`=3 -> `step`=0, `seq_cnt`=0, no `done`; preload `seq_cnt`=2^16−1 via repeated sequences -> next `done` gives 0.

Source files
------------

// File: rtl/edge_seq_tracker_pkg.sv
// Shared types and idle input levels for the edge-sequence tracker.
package edge_seq_pkg;

  typedef enum logic [1:0] {ST_A, ST_B, ST_C, ST_D} seq_state_t;

  localparam logic SIG1_RST = 1'b0;
  localparam logic SIG2_RST = 1'b1;

endpackage

// File: rtl/edge_seq_tracker_edge_det2.sv
// Two-signal edge detector; previous-value registers reset to the idle levels
// so that idle inputs coming out of reset produce no edge.
module edge_det2 #(
  parameter logic RST1 = 1'b0,
  parameter logic RST2 = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig1,
  input  logic sig2,
  output logic rise1,
  output logic fall1,
  output logic rise2,
  output logic fall2
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST1;
      s2_q <= RST2;
    end else begin
      s1_q <= sig1;
      s2_q <= sig2;
    end
  end

  assign rise1 = sig1 & ~s1_q;
  assign fall1 = ~sig1 & s1_q;
  assign rise2 = sig2 & ~s2_q;
  assign fall2 = ~sig2 & s2_q;

endmodule

// File: rtl/edge_seq_tracker.sv
// Four-step edge/event sequence tracker with per-step timeout, hit/done/timeout
// pulses, saturating wait counter and wrapping completed-sequence counter.
module edge_seq_tracker
  import edge_seq_pkg::*;
#(
  parameter int unsigned TMO_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ev,
  input  logic             sig1,
  input  logic             sig2,
  input  logic [TMO_W-1:0] tmo_lim,
  output logic [1:0]       step,
  output logic             hit,
  output logic [1:0]       hit_step,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] seq_cnt,
  output logic [TMO_W-1:0] wait_cyc
);

  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise1, fall1, rise2, fall2;

  edge_det2 #(
    .RST1 (SIG1_RST),
    .RST2 (SIG2_RST)
  ) u_edge (
    .clk   (clk),
    .rst   (rst),
    .sig1  (sig1),
    .sig2  (sig2),
    .rise1 (rise1),
    .fall1 (fall1),
    .rise2 (rise2),
    .fall2 (fall2)
  );

  seq_state_t       state, state_n;
  logic             cond;
  logic             hit_n, done_n, tmo_n;
  logic [1:0]       hit_step_n;
  logic [CNT_W-1:0] cnt_n;
  logic [TMO_W-1:0] wait_n;

  // Only the current step's wake condition is looked at.
  always_comb begin
    cond = 1'b0;
    unique case (state)
      ST_A: cond = rise1 | ev;
      ST_B: cond = rise2 | ev;
      ST_C: cond = rise1 | fall2;
      ST_D: cond = fall1 | rise2;
    endcase
  end

  always_comb begin
    state_n    = state;
    wait_n     = wait_cyc;
    cnt_n      = seq_cnt;
    hit_n      = 1'b0;
    hit_step_n = hit_step;
    done_n     = 1'b0;
    tmo_n      = 1'b0;
    if (en) begin
      if (cond) begin
        hit_n      = 1'b1;
        hit_step_n = state;
        wait_n     = '0;
        if (state == ST_D) begin
          state_n = ST_A;
          done_n  = 1'b1;
          cnt_n   = seq_cnt + CNT_ONE;
        end else begin
          state_n = seq_state_t'(state + 2'd1);
        end
      end else if (tmo_lim != '0 && wait_cyc == tmo_lim - TMO_ONE) begin
        state_n = ST_A;
        tmo_n   = 1'b1;
        wait_n  = '0;
      end else if (wait_cyc != '1) begin
        wait_n = wait_cyc + TMO_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_A;
      hit      <= 1'b0;
      hit_step <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      seq_cnt  <= '0;
      wait_cyc <= '0;
    end else begin
      state    <= state_n;
      hit      <= hit_n;
      hit_step <= hit_step_n;
      done     <= done_n;
      timeout  <= tmo_n;
      seq_cnt  <= cnt_n;
      wait_cyc <= wait_n;
    end
  end

  assign step = state;

endmodule
